// File: rtl/spi_reg_sequencer.sv
// Command/register sequencer behind an 8-bit SPI slave: each SS-framed stream is {cmd, data...},
// cmd = {rw, addr}; drives an auto-incrementing register bus and supplies the slave's tx byte.
//   state    | meaning
//   ST_IDLE  | no frame; waiting for a fresh select edge
//   ST_CMD   | frame open, expecting the command byte
//   ST_WRITE | each received byte becomes a write at the running address
//   ST_READ  | each received byte prefetches the next register into tx_hold
module spi_reg_sequencer #(
  parameter int unsigned ADDR_W = 7,
  parameter logic [7:0]  STATUS = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_ss,
  input  logic [7:0]        spi_rxdata,
  input  logic              spi_rxready,
  input  logic              spi_txready,
  output logic [7:0]        spi_txdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WRITE, ST_READ} state_t;

  state_t            state_q, state_d;
  logic              ss_meta_q, ss_sync_q;
  logic              sel_prev_q, sel_prev_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              rd_pend_q, rd_pend_d;
  logic [7:0]        tx_hold_q, tx_hold_d;
  logic              sel;
  logic              accept;
  logic              unused_txready;

  assign unused_txready = spi_txready;
  assign sel            = ~ss_sync_q;
  assign accept         = sel & spi_rxready;

  // The synchroniser and edge history reset to "selected" so a frame held open across
  // reset cannot masquerade as a new select edge; only a real high-then-low SS restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_meta_q  <= 1'b0;
      ss_sync_q  <= 1'b0;
      sel_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
    end else begin
      ss_meta_q  <= spi_ss;
      ss_sync_q  <= ss_meta_q;
      sel_prev_q <= sel_prev_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    sel_prev_d = sel;
    state_d    = state_q;
    unique case (state_q)
      ST_IDLE:  if (sel && !sel_prev_q) state_d = ST_CMD;
      ST_CMD: begin
        if (!sel)             state_d = ST_IDLE;
        else if (spi_rxready) state_d = spi_rxdata[7] ? ST_READ : ST_WRITE;
      end
      ST_WRITE: if (!sel) state_d = ST_IDLE;
      ST_READ:  if (!sel) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      tx_hold_q   <= 8'h00;
    end else begin
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      rd_pend_q   <= rd_pend_d;
      tx_hold_q   <= tx_hold_d;
    end
  end

  always_comb begin
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    rd_pend_d   = reg_re_q;
    tx_hold_d   = tx_hold_q;
    // Address advances once the access at the current address has completed.
    if (reg_we_q || rd_pend_q) reg_addr_d = reg_addr_q + ADDR_W'(1);
    if (rd_pend_q) tx_hold_d = reg_rdata;
    unique case (state_q)
      ST_CMD: begin
        if (accept) begin
          reg_addr_d = spi_rxdata[ADDR_W-1:0];
          reg_re_d   = spi_rxdata[7];
        end
      end
      ST_WRITE: begin
        if (accept) begin
          reg_we_d    = 1'b1;
          reg_wdata_d = spi_rxdata;
        end
      end
      ST_READ:  if (accept) reg_re_d = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    spi_txdata = STATUS;
    unique case (state_q)
      ST_WRITE: spi_txdata = 8'h00;
      ST_READ:  spi_txdata = tx_hold_q;
      default:  spi_txdata = STATUS;
    endcase
  end

  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer: frame-level model predicts writes, reads and bytes returned
// to the master; a negedge process checks every strobe and every tx capture against it.
module tb_spi_reg_sequencer;
  localparam logic [7:0] STATUS = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, spi_ss, spi_rxready, spi_txready;
  logic [7:0] spi_rxdata, spi_txdata, reg_wdata, reg_rdata;
  logic [6:0] reg_addr;
  logic       reg_we, reg_re, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_reg_sequencer dut (
    .clk(clk), .reset(reset), .spi_ss(spi_ss), .spi_rxdata(spi_rxdata),
    .spi_rxready(spi_rxready), .spi_txready(spi_txready), .spi_txdata(spi_txdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register file on the bus: read data valid only the cycle after reg_re, noise otherwise.
  logic [7:0] bus_mem [128];
  logic [7:0] model_mem [128];
  logic [7:0] rdata_q;
  always @(posedge clk) begin
    if (reg_we) bus_mem[reg_addr] <= reg_wdata;
    rdata_q <= reg_re ? bus_mem[reg_addr] : 8'($urandom);
  end
  assign reg_rdata = rdata_q;

  logic [14:0] exp_w[$], obs_w[$];
  logic [6:0]  exp_r[$], obs_r[$];
  logic [7:0]  exp_tx[$], obs_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL unexpected_%s: got %0h expected none", name, act);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("strobe_overlap", 32'(reg_we & reg_re), 32'd0);
      if (reg_we) begin
        obs_w.push_back({reg_addr, reg_wdata});
        if (exp_w.size() == 0) unexpected("write", 32'({reg_addr, reg_wdata}));
        else check("write", 32'({reg_addr, reg_wdata}), 32'(exp_w.pop_front()));
      end
      if (reg_re) begin
        obs_r.push_back(reg_addr);
        if (exp_r.size() == 0) unexpected("read", 32'(reg_addr));
        else check("read_addr", 32'(reg_addr), 32'(exp_r.pop_front()));
      end
      if (spi_txready) begin
        obs_tx.push_back(spi_txdata);
        if (exp_tx.size() == 0) unexpected("txready", 32'(spi_txdata));
        else check("txdata", 32'(spi_txdata), 32'(exp_tx.pop_front()));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tx;
    step;
    spi_txready = 1'b1;
    step;
    spi_txready = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    step;
    spi_rxdata  = d;
    spi_rxready = 1'b1;
    step;
    spi_rxready = 1'b0;
  endtask

  // nfull bytes complete (command included); tail 1 = one more slot started then SS raised,
  // tail 2 = that extra byte arrives exactly as the deselect reaches the sequencer.
  task automatic model_frame(input logic [7:0] b [8], input int nfull, input int tail);
    logic [6:0] a;
    int         nslots;
    exp_tx.push_back(STATUS);
    a      = b[0][6:0];
    nslots = nfull - 1 + ((tail != 0) ? 1 : 0);
    if (!b[0][7]) begin
      for (int i = 0; i < nfull - 1; i++) begin
        exp_w.push_back({a + 7'(i), b[i+1]});
        model_mem[a + 7'(i)] = b[i+1];
      end
      for (int k = 0; k < nslots; k++) exp_tx.push_back(8'h00);
    end else begin
      for (int i = 0; i < nfull; i++) exp_r.push_back(a + 7'(i));
      for (int k = 0; k < nslots; k++) exp_tx.push_back(model_mem[a + 7'(k)]);
    end
  endtask

  task automatic run_frame(input logic [7:0] b [8], input int nfull, input int tail);
    model_frame(b, nfull, tail);
    obs_w.delete();
    obs_r.delete();
    obs_tx.delete();
    step;
    spi_ss = 1'b0;
    repeat (4) step;
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int k = 0; k < nfull; k++) begin
      pulse_tx;
      repeat ($urandom_range(16, 8)) step;
      pulse_rx(b[k]);
      repeat ($urandom_range(9, 5)) step;
    end
    if (tail != 0) begin
      pulse_tx;
      repeat ($urandom_range(6, 3)) step;
      spi_ss = 1'b1;
      if (tail == 2) begin
        step;
        pulse_rx(b[nfull]);
      end
    end else begin
      spi_ss = 1'b1;
    end
    repeat (6) step;
    check("busy_after_frame", 32'(busy), 32'd0);
    check("writes_left", 32'(exp_w.size()), 32'd0);
    check("reads_left", 32'(exp_r.size()), 32'd0);
    check("tx_left", 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    check({tag, "_we"}, 32'(reg_we), 32'd0);
    check({tag, "_re"}, 32'(reg_re), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_txdata"}, 32'(spi_txdata), 32'(STATUS));
  endtask

  task automatic check_test2(input string tag);
    check({tag, "_ntx"}, 32'(obs_tx.size()), 32'd3);
    if (obs_tx.size() == 3) begin
      check({tag, "_tx0"}, 32'(obs_tx[0]), 32'hA5);
      check({tag, "_tx1"}, 32'(obs_tx[1]), 32'h3C);
      check({tag, "_tx2"}, 32'(obs_tx[2]), 32'h7E);
    end
    check({tag, "_nrd"}, 32'(obs_r.size()), 32'd3);
    if (obs_r.size() == 3) begin
      check({tag, "_rd0"}, 32'(obs_r[0]), 32'h10);
      check({tag, "_rd1"}, 32'(obs_r[1]), 32'h11);
      check({tag, "_rd2"}, 32'(obs_r[2]), 32'h12);
    end
  endtask

  logic [7:0] fb [8];
  logic [7:0] v;

  initial begin
    reset = 1'b1; spi_ss = 1'b1; spi_rxready = 1'b0; spi_txready = 1'b0; spi_rxdata = 8'h00;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      bus_mem[i] <= v;
      model_mem[i] = v;
    end
    repeat (3) step;
    reset = 1'b0;
    check_reset_outputs("reset");
    repeat (5) step;

    // write burst
    fb = '{8'h05, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 3, 0);
    check("t1_nw", 32'(obs_w.size()), 32'd2);
    if (obs_w.size() == 2) begin
      check("t1_w0", 32'(obs_w[0]), 32'h0511);
      check("t1_w1", 32'(obs_w[1]), 32'h0622);
    end
    check("t1_ntx", 32'(obs_tx.size()), 32'd3);
    if (obs_tx.size() == 3) begin
      check("t1_tx0", 32'(obs_tx[0]), 32'hA5);
      check("t1_tx1", 32'(obs_tx[1]), 32'h00);
      check("t1_tx2", 32'(obs_tx[2]), 32'h00);
    end

    // read burst
    bus_mem[8'h10] <= 8'h3C; model_mem[7'h10] = 8'h3C;
    bus_mem[8'h11] <= 8'h7E; model_mem[7'h11] = 8'h7E;
    fb = '{8'h90, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 3, 0);
    check_test2("t2");

    // address wrap
    fb = '{8'h7F, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 3, 0);
    check("t3_nw", 32'(obs_w.size()), 32'd2);
    if (obs_w.size() == 2) begin
      check("t3_w0", 32'(obs_w[0]), 32'h7FAA);
      check("t3_w1", 32'(obs_w[1]), 32'h00BB);
    end

    // abort mid second data byte, then a fresh frame
    fb = '{8'h20, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 2, 1);
    check("t4_nw", 32'(obs_w.size()), 32'd1);
    fb = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 1, 0);
    check("t6_nw", 32'(obs_w.size()), 32'd0);
    check("t4_next_status", 32'(obs_tx.size() > 0 ? obs_tx[0] : 8'h00), 32'hA5);
    fb = '{8'h83, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 1, 0);
    check("t6_nrd", 32'(obs_r.size()), 32'd1);
    if (obs_r.size() == 1) check("t6_rd0", 32'(obs_r[0]), 32'h03);

    // byte landing on the deselect cycle is discarded
    fb = '{8'h40, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 2, 2);
    check("coincident_nw", 32'(obs_w.size()), 32'd1);

    // reset in the middle of a read frame with SS held low
    exp_tx.push_back(STATUS); exp_tx.push_back(8'h3C);
    exp_r.push_back(7'h10); exp_r.push_back(7'h11);
    step;
    spi_ss = 1'b0;
    repeat (4) step;
    pulse_tx; repeat (10) step; pulse_rx(8'h90); repeat (6) step;
    pulse_tx; repeat (10) step; pulse_rx(8'hFF); repeat (6) step;
    reset = 1'b1;
    repeat (2) step;
    reset = 1'b0;
    check_reset_outputs("midreset");
    exp_tx.push_back(STATUS);
    repeat (20) step;
    pulse_tx; repeat (10) step; pulse_rx(8'h90); repeat (10) step;
    check("midreset_busy_held", 32'(busy), 32'd0);
    check("midreset_reads_left", 32'(exp_r.size()), 32'd0);
    spi_ss = 1'b1;
    repeat (6) step;
    fb = '{8'h90, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 3, 0);
    check_test2("t5");

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < 8; j++) fb[j] = 8'($urandom);
      run_frame(fb, $urandom_range(5, 1), $urandom_range(2, 0));
      repeat ($urandom_range(8, 2)) step;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
